combo_lock_ctrl: RTL and testbench
==================================

# combo_lock_ctrl

Sequencing controller for the combination lock. Consumes one-cycle button pulses from the per-button level-to-pulse converters and steps them through a digit-entry state machine. It compares the entered digits against a programmable code register and drives the unlock, fail and lockout status. It sits between the button edge detectors and the lock actuator/indicator logic.

## Interface
- `CODE_LEN`, 4: digits per code, legal 1..7.
- `DEFAULT_CODE`, 8'b00_01_10_11: reset code, 2*CODE_LEN bits, first digit in MSBs.
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout, legal 1..7.
- `LOCKOUT_CYCLES`, 50000: lockout duration in clk cycles, at least 1.
- `TIMEOUT_CYCLES`, 100000: idle cycles allowed between presses during entry, at least 1.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `btn` in 4: button pulses, one cycle each; bit k pressed = digit k.
- `relock` in 1: pulse; relocks from OPEN/PROGRAM.
- `set_code` in 1: pulse; enters PROGRAM from OPEN.
- `unlocked` out 1: high in OPEN and PROGRAM.
- `programming` out 1: high in PROGRAM.
- `fail` out 1: one-cycle pulse per rejected attempt.
- `locked_out` out 1: high during LOCKOUT.
- `digits` out 3: digits accepted in current entry/program sequence.
- `fail_count` out 3: consecutive failures since last success or lockout.

## Operation
- Press = `btn` != 0 in a cycle. One-hot → digit 0..3. Multi-hot → invalid digit (never matches).
- Code digit i (i=0 first) = code_reg[2*(CODE_LEN-1-i)+1 -: 2]. code_reg resets to DEFAULT_CODE; reset always restores it.
- States: LOCKED, ENTRY, OPEN, PROGRAM, LOCKOUT. Reset → LOCKED, all outputs 0, counters 0.
- LOCKED: on a press, record a match/mismatch flag, set digits=1, go to ENTRY. If CODE_LEN=1, decide immediately.
- ENTRY: each press increments digits and ANDs in the match result. On the CODE_LEN-th press, decide:
  - All matched: go to OPEN, fail_count=0.
  - Else: pulse fail, fail_count+1. At MAX_FAIL go to LOCKOUT, otherwise go to LOCKED. digits returns to 0 in both cases.
- Entry timeout: if no press for TIMEOUT_CYCLES cycles, return to LOCKED with digits=0. No fail and no fail_count change.
- OPEN: `btn` is ignored.
  - relock → LOCKED.
  - set_code → PROGRAM with digits=0.
  - relock and set_code in the same cycle: relock wins.
- PROGRAM: each one-hot press shifts a digit into a shadow register.
  - On the CODE_LEN-th digit, copy shadow to code_reg and return to OPEN.
  - A multi-hot press, a timeout or set_code aborts: code unchanged, return to OPEN.
  - relock aborts to LOCKED with the code unchanged.
- LOCKOUT: locked_out=1, all inputs ignored, for exactly LOCKOUT_CYCLES cycles. Then go to LOCKED with fail_count=0.
- relock/set_code are ignored outside OPEN/PROGRAM.

## Timing
- All outputs are registered; no combinational input→output path.
- Press sampled at edge N: digits updates at N+1.
- Final-digit press at N: unlocked=1, or fail=1 for exactly one cycle, starting at N+1. locked_out rises at N+1 if the limit is hit.
- Lockout: locked_out high for cycles N+1..N+LOCKOUT_CYCLES. LOCKED from N+LOCKOUT_CYCLES+1, where a press is accepted.
- Timeout: with the last press at P and no press in P+1..P+TIMEOUT_CYCLES, the block is LOCKED/OPEN at P+TIMEOUT_CYCLES+1. A press at P+TIMEOUT_CYCLES is accepted and restarts the idle count.
- The idle counter is cleared on every accepted press and on every state entry.
- relock/set_code at N: state changes at N+1.
- New code is used from the first entry after returning to OPEN and relocking.
- Reset asserted mid-sequence: immediate return to LOCKED, all outputs 0, code = DEFAULT_CODE.

## Test plan
Bench overrides: TIMEOUT_CYCLES=20, LOCKOUT_CYCLES=10.
- Correct code: press 0001,0010,0100,1000 with gaps of 3 → unlocked=1 one cycle after the 4th press, fail_count=0, no fail pulse.
- Wrong code three times: press 1000 ×4, three times → fail pulses 1,2,3. locked_out=1 for exactly 10 cycles after the 3rd attempt. Presses during lockout are ignored (digits stays 0). Afterwards fail_count=0 and the correct code unlocks.
- Multi-hot and timeout: press 0011 as digit 2 → fail after the 4th press. Separately: 2 presses, then 20 idle cycles → LOCKED, digits=0, fail_count unchanged. A press on idle cycle 20 is instead accepted.
- Reprogram: unlock, set_code, press 1000,0100,0010,0001, relock → old code fails, new code unlocks. A repeat with a multi-hot press aborts and keeps the code.
- Simultaneous inputs: in OPEN, relock+set_code same cycle → LOCKED, programming=0.
- Reset mid-sequence: reset after 2 digits → all outputs 0 immediately.
- Reset after reprogramming: DEFAULT_CODE unlocks.

Source files
------------

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: digit entry, code compare, fail/lockout tracking
// and in-field reprogramming of the code register.
`timescale 1ns/1ps
module combo_lock_ctrl #(
  parameter int unsigned           CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE   = 8'b00_01_10_11,
  parameter int unsigned           MAX_FAIL       = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 50000,
  parameter int unsigned           TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] btn_i,
  input  logic       relock_i,
  input  logic       set_code_i,
  output logic       unlocked_o,
  output logic       programming_o,
  output logic       fail_o,
  output logic       locked_out_o,
  output logic [2:0] digits_o,
  output logic [2:0] fail_count_o
);

  localparam int unsigned CW   = 2 * CODE_LEN;
  localparam int unsigned IW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW   = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0]  LEN3 = 3'(CODE_LEN);
  localparam logic [2:0]  MF3  = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_LOCKED, S_ENTRY, S_OPEN, S_PROGRAM, S_LOCKOUT
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   code_q, shadow_q;
  logic            match_q;
  logic [2:0]      digits_q, fail_cnt_q;
  logic [IW-1:0]   idle_q;
  logic [LW-1:0]   lock_q;
  logic            unlocked_q, programming_q, fail_q, locked_out_q;

  logic            press, onehot, hit, last, idle_done;
  logic [1:0]      dig, exp_dig;
  logic [2:0]      cnt;

  always_comb begin
    press  = |btn_i;
    onehot = $onehot(btn_i);
    case (btn_i)
      4'b0010: dig = 2'd1;
      4'b0100: dig = 2'd2;
      4'b1000: dig = 2'd3;
      default: dig = 2'd0;
    endcase
    exp_dig = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++)
      if (digits_q == 3'(i)) exp_dig = code_q[2*(CODE_LEN-1-i)+1 -: 2];
    cnt       = digits_q + 3'd1;
    last      = (cnt == LEN3);
    // Match flag carries across the whole attempt; a multi-hot press poisons it.
    hit       = onehot && (dig == exp_dig) && ((state_q == S_LOCKED) || match_q);
    idle_done = (idle_q == IW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_LOCKED;
      code_q        <= DEFAULT_CODE;
      shadow_q      <= '0;
      match_q       <= 1'b0;
      digits_q      <= '0;
      fail_cnt_q    <= '0;
      idle_q        <= '0;
      lock_q        <= '0;
      unlocked_q    <= 1'b0;
      programming_q <= 1'b0;
      fail_q        <= 1'b0;
      locked_out_q  <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      case (state_q)
        S_LOCKED, S_ENTRY: begin
          if (press) begin
            idle_q <= '0;
            if (last) begin
              digits_q <= '0;
              if (hit) begin
                state_q    <= S_OPEN;
                unlocked_q <= 1'b1;
                fail_cnt_q <= '0;
              end else begin
                fail_q     <= 1'b1;
                fail_cnt_q <= fail_cnt_q + 3'd1;
                if (fail_cnt_q + 3'd1 == MF3) begin
                  state_q      <= S_LOCKOUT;
                  locked_out_q <= 1'b1;
                  lock_q       <= '0;
                end else begin
                  state_q <= S_LOCKED;
                end
              end
            end else begin
              state_q  <= S_ENTRY;
              digits_q <= cnt;
              match_q  <= hit;
            end
          end else if (state_q == S_ENTRY) begin
            if (idle_done) begin
              state_q  <= S_LOCKED;
              digits_q <= '0;
              idle_q   <= '0;
            end else begin
              idle_q <= idle_q + IW'(1);
            end
          end
        end
        S_OPEN: begin
          if (relock_i) begin
            state_q    <= S_LOCKED;
            unlocked_q <= 1'b0;
          end else if (set_code_i) begin
            state_q       <= S_PROGRAM;
            programming_q <= 1'b1;
            digits_q      <= '0;
            idle_q        <= '0;
          end
        end
        S_PROGRAM: begin
          if (relock_i) begin
            state_q       <= S_LOCKED;
            unlocked_q    <= 1'b0;
            programming_q <= 1'b0;
            digits_q      <= '0;
          end else if (set_code_i || (press && !onehot) || (!press && idle_done)) begin
            state_q       <= S_OPEN;
            programming_q <= 1'b0;
            digits_q      <= '0;
            idle_q        <= '0;
          end else if (press) begin
            idle_q <= '0;
            if (last) begin
              code_q        <= (shadow_q << 2) | CW'(dig);
              state_q       <= S_OPEN;
              programming_q <= 1'b0;
              digits_q      <= '0;
            end else begin
              shadow_q <= (shadow_q << 2) | CW'(dig);
              digits_q <= cnt;
            end
          end else begin
            idle_q <= idle_q + IW'(1);
          end
        end
        S_LOCKOUT: begin
          if (lock_q == LW'(LOCKOUT_CYCLES - 1)) begin
            state_q      <= S_LOCKED;
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
          end else begin
            lock_q <= lock_q + LW'(1);
          end
        end
        default: state_q <= S_LOCKED;
      endcase
    end
  end

  assign unlocked_o    = unlocked_q;
  assign programming_o = programming_q;
  assign fail_o        = fail_q;
  assign locked_out_o  = locked_out_q;
  assign digits_o      = digits_q;
  assign fail_count_o  = fail_cnt_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: vector table, directed corner
// sequences and random stimulus against a queue-based reference model.
`timescale 1ns/1ps
module tb_combo_lock_ctrl;
  localparam int TO = 20;
  localparam int LO = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       relock, set_code;
  logic       unlocked, programming, fail, locked_out;
  logic [2:0] digits, fail_count;

  int checks = 0;
  int errors = 0;

  combo_lock_ctrl #(
    .CODE_LEN(4), .DEFAULT_CODE(8'b00_01_10_11), .MAX_FAIL(3),
    .LOCKOUT_CYCLES(LO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .reset_i(rst), .btn_i(btn), .relock_i(relock),
    .set_code_i(set_code), .unlocked_o(unlocked), .programming_o(programming),
    .fail_o(fail), .locked_out_o(locked_out), .digits_o(digits),
    .fail_count_o(fail_count)
  );

  always #5 clk = ~clk;

  // Reference model: digits held in a queue, code as an array of digits.
  int  code[4];
  int  entered[$];
  bit  m_open, m_prog, m_fail;
  int  m_lock_left, m_fails, m_idle;

  function automatic logic [9:0] ex(bit u, bit p, bit f, bit lo, int d, int fc);
    return {u, p, f, lo, 3'(d), 3'(fc)};
  endfunction

  function automatic logic [9:0] dut_out();
    return {unlocked, programming, fail, locked_out, digits, fail_count};
  endfunction

  function automatic logic [9:0] mdl_out();
    return ex(m_open, m_prog, m_fail, m_lock_left > 0, entered.size(), m_fails);
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got u/p/f/lo/dig/fc=%b/%b/%b/%b/%0d/%0d required %b/%b/%b/%b/%0d/%0d",
               name, act[9], act[8], act[7], act[6], act[5:3], act[2:0],
               exp[9], exp[8], exp[7], exp[6], exp[5:3], exp[2:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) code[k] = k;
    entered.delete();
    m_open = 0; m_prog = 0; m_fail = 0;
    m_lock_left = 0; m_fails = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic [3:0] b, input bit r, input bit s);
    bit oh, ok;
    int d;
    oh = (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    d  = -1;
    for (int k = 0; k < 4; k++) if (oh && b[k]) d = k;
    m_fail = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_prog) begin
      if (r) begin
        m_prog = 0; m_open = 0; entered.delete();
      end else if (s || (b != 4'd0 && !oh)) begin
        m_prog = 0; entered.delete();
      end else if (b != 4'd0) begin
        entered.push_back(d); m_idle = 0;
        if (entered.size() == 4) begin
          for (int k = 0; k < 4; k++) code[k] = entered[k];
          entered.delete(); m_prog = 0;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_prog = 0; entered.delete(); end
      end
    end else if (m_open) begin
      if (r) m_open = 0;
      else if (s) begin m_prog = 1; m_idle = 0; entered.delete(); end
    end else if (b != 4'd0) begin
      entered.push_back(d); m_idle = 0;
      if (entered.size() == 4) begin
        ok = 1;
        for (int k = 0; k < 4; k++) if (entered[k] != code[k]) ok = 0;
        entered.delete();
        if (ok) begin
          m_open = 1; m_fails = 0;
        end else begin
          m_fail = 1; m_fails++;
          if (m_fails == 3) m_lock_left = LO;
        end
      end
    end else if (entered.size() > 0) begin
      m_idle++;
      if (m_idle == TO) entered.delete();
    end
  endtask

  task automatic apply(input logic [3:0] b, input bit r, input bit s, input string name);
    btn = b; relock = r; set_code = s;
    model_step(b, r, s);
    @(posedge clk); #1;
    btn = '0; relock = 1'b0; set_code = 1'b0;
    check(name, dut_out(), mdl_out());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(4'd0, 1'b0, 1'b0, "idle");
  endtask

  task automatic enter(input int d0, input int d1, input int d2, input int d3, input int gap);
    apply(4'(1 << d0), 1'b0, 1'b0, "digit"); idle(gap);
    apply(4'(1 << d1), 1'b0, 1'b0, "digit"); idle(gap);
    apply(4'(1 << d2), 1'b0, 1'b0, "digit"); idle(gap);
    apply(4'(1 << d3), 1'b0, 1'b0, "digit");
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = '0; relock = 1'b0; set_code = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'd0, 1'b0, 1'b0, "post_reset");
  endtask

  typedef struct {
    logic [3:0] b;
    bit         r;
    bit         s;
    logic [9:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input logic [3:0] b, input bit r, input bit s, input logic [9:0] e);
    vec_t v;
    v.b = b; v.r = r; v.s = s; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_n;

    // Correct default code with gaps of 3, relock, then one wrong attempt.
    row(4'b0001, 0, 0, ex(0,0,0,0,1,0));
    for (int k = 0; k < 3; k++) row(4'b0000, 0, 0, ex(0,0,0,0,1,0));
    row(4'b0010, 0, 0, ex(0,0,0,0,2,0));
    for (int k = 0; k < 3; k++) row(4'b0000, 0, 0, ex(0,0,0,0,2,0));
    row(4'b0100, 0, 0, ex(0,0,0,0,3,0));
    for (int k = 0; k < 3; k++) row(4'b0000, 0, 0, ex(0,0,0,0,3,0));
    row(4'b1000, 0, 0, ex(1,0,0,0,0,0));
    row(4'b0101, 0, 0, ex(1,0,0,0,0,0));
    row(4'b0000, 1, 0, ex(0,0,0,0,0,0));
    row(4'b1000, 0, 0, ex(0,0,0,0,1,0));
    row(4'b1000, 0, 0, ex(0,0,0,0,2,0));
    row(4'b1000, 0, 0, ex(0,0,0,0,3,0));
    row(4'b1000, 0, 0, ex(0,0,1,0,0,1));
    row(4'b0000, 0, 1, ex(0,0,0,0,0,1));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].b, tbl[i].r, tbl[i].s, $sformatf("vec%0d_model", i));
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Three wrong attempts -> lockout for exactly LO cycles, presses ignored.
    do_reset();
    for (int a = 1; a <= 3; a++) begin
      enter(3, 3, 3, 3, 0);
      check_int("fail_pulse", int'(fail), 1);
      check_int("fail_count_step", int'(fail_count), a);
    end
    check_int("lockout_rise", int'(locked_out), 1);
    lo_n = 0;
    for (int c = 0; c < 3 * LO && locked_out; c++) begin
      lo_n++;
      apply(4'b0001, 1'b0, 1'b0, "lockout_press");
      check_int("lockout_digits", int'(digits), 0);
    end
    check_int("lockout_len", lo_n, LO);
    check_int("fail_count_after_lockout", int'(fail_count), 0);
    enter(0, 1, 2, 3, 1);
    check_int("unlock_after_lockout", int'(unlocked), 1);

    // Multi-hot digit never matches.
    do_reset();
    apply(4'b0001, 1'b0, 1'b0, "d0");
    apply(4'b0010, 1'b0, 1'b0, "d1");
    apply(4'b0011, 1'b0, 1'b0, "multi");
    apply(4'b1000, 1'b0, 1'b0, "d3");
    check("multihot_fail", dut_out(), ex(0,0,1,0,0,1));

    // Entry timeout: abandons without a fail; a press on idle cycle TO is kept.
    enter(0, 1, 0, 0, 0);
    do_reset();
    apply(4'b0001, 1'b0, 1'b0, "t0");
    apply(4'b0010, 1'b0, 1'b0, "t1");
    idle(TO - 1);
    check_int("timeout_not_yet", int'(digits), 2);
    idle(1);
    check("timeout_locked", dut_out(), ex(0,0,0,0,0,0));
    apply(4'b0001, 1'b0, 1'b0, "t2");
    apply(4'b0010, 1'b0, 1'b0, "t3");
    idle(TO - 1);
    apply(4'b0100, 1'b0, 1'b0, "late_press");
    check_int("late_press_accepted", int'(digits), 3);
    apply(4'b1000, 1'b0, 1'b0, "late_final");
    check_int("late_unlock", int'(unlocked), 1);

    // Reprogram to 3,2,1,0.
    apply(4'd0, 1'b0, 1'b1, "set_code");
    check("program_enter", dut_out(), ex(1,1,0,0,0,0));
    enter(3, 2, 1, 0, 1);
    check("program_done", dut_out(), ex(1,0,0,0,0,0));
    apply(4'd0, 1'b1, 1'b0, "relock");
    enter(0, 1, 2, 3, 0);
    check_int("old_code_fails", int'(fail), 1);
    enter(3, 2, 1, 0, 0);
    check_int("new_code_unlocks", int'(unlocked), 1);
    apply(4'd0, 1'b0, 1'b1, "set_code2");
    apply(4'b0001, 1'b0, 1'b0, "p0");
    apply(4'b0011, 1'b0, 1'b0, "p_multi");
    check("program_abort", dut_out(), ex(1,0,0,0,0,0));
    apply(4'd0, 1'b1, 1'b0, "relock2");
    enter(3, 2, 1, 0, 0);
    check_int("code_kept", int'(unlocked), 1);
    apply(4'd0, 1'b1, 1'b1, "relock_and_set");
    check("relock_wins", dut_out(), ex(0,0,0,0,0,0));

    // Reset mid-sequence.
    apply(4'b1000, 1'b0, 1'b0, "m0");
    apply(4'b0100, 1'b0, 1'b0, "m1");
    check_int("mid_digits", int'(digits), 2);
    do_reset();
    enter(0, 1, 2, 3, 0);
    check_int("default_after_reset", int'(unlocked), 1);

    // Random stimulus, biased toward the current code digit.
    for (int c = 0; c < 2000; c++) begin
      int r;
      logic [3:0] b;
      bit rl, sc;
      r = int'($urandom_range(0, 99));
      b = '0; rl = 1'b0; sc = 1'b0;
      if (r < 25)      b = 4'(1 << code[entered.size() % 4]);
      else if (r < 33) b = 4'(1 << $urandom_range(0, 3));
      else if (r < 36) b = 4'($urandom_range(1, 15));
      else if (r < 40) rl = 1'b1;
      else if (r < 45) sc = 1'b1;
      if (r == 99) idle(TO + 2);
      else apply(b, rl, sc, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
